// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking zone controller: gate FSM states,
// the hour-of-day public capacity schedule and a saturating vacancy difference.
package parking_pkg;

  typedef enum logic [1:0] {IDLE, OPEN, RELEASE} gate_state_t;

  localparam int BONUS_H13 = 50;
  localparam int BONUS_H14 = 100;
  localparam int BONUS_H15 = 150;
  localparam int BONUS_H16 = 300;

  function automatic int hour_capacity(input logic [4:0] hour, input int base);
    case (hour)
      5'd13:   return base + BONUS_H13;
      5'd14:   return base + BONUS_H14;
      5'd15:   return base + BONUS_H15;
      5'd16:   return base + BONUS_H16;
      default: return base;
    endcase
  endfunction

  function automatic int vac_sat(input int cap, input int occ);
    return (cap > occ) ? cap - occ : 0;
  endfunction

endpackage

// File: rtl/parking_zone_counter.sv
// One zone's occupancy counter: decrements (1 or 2) apply before the increment, floored at 0.
// Count, vacancy and full update together on the clock edge; underflow is combinational.
module parking_zone_counter
  import parking_pkg::*;
#(
  parameter int CNT_W   = 10,
  parameter int RST_CAP = 200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             dec2,
  input  logic [CNT_W-1:0] cap,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] vacancy,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W-1:0] after_dec;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] vac_d;

  always_comb begin
    after_dec = count;
    underflow = 1'b0;
    if (dec2) begin
      if (count >= CNT_W'(2)) after_dec = count - CNT_W'(2);
      else begin
        after_dec = '0;
        underflow = 1'b1;
      end
    end else if (dec) begin
      if (count != '0) after_dec = count - CNT_W'(1);
      else             underflow = 1'b1;
    end
    count_d = after_dec;
    if (inc && (after_dec != '1)) count_d = after_dec + CNT_W'(1);
    vac_d = CNT_W'(vac_sat(int'(cap), int'(count_d)));
  end

  // Vacancy is derived from the next count so it never lags occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      vacancy <= CNT_W'(RST_CAP);
      full    <= 1'b0;
    end else begin
      count   <= count_d;
      vacancy <= vac_d;
      full    <= (vac_d == '0);
    end
  end

endmodule

// File: rtl/parking_zone_controller.sv
// Multi-zone parking controller: entry req/ack with gate FSM, exit handling, hourly public capacity.
// Ack one cycle after req in IDLE; req is held (not acked) while the gate is OPEN/RELEASE. Macro PARK_STATS_EN adds reject_cnt.
module parking_zone_controller
  import parking_pkg::*;
#(
  parameter int NUM_ZONES    = 2,
  parameter int CNT_W        = 10,
  parameter int RSV_CAP      = 500,
  parameter int PUB_BASE_CAP = 200,
  parameter int GATE_TIMEOUT = 16,
  localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [4:0]                 current_hour,
  input  logic                       entry_req,
  input  logic [ZW-1:0]              entry_zone,
  output logic                       entry_ack,
  output logic                       entry_grant,
  output logic                       gate_open,
  input  logic                       car_passed,
  input  logic                       exit_pulse,
  input  logic [ZW-1:0]              exit_zone,
  output logic                       exit_err,
  output logic [NUM_ZONES*CNT_W-1:0] occupancy,
  output logic [NUM_ZONES*CNT_W-1:0] vacancy,
`ifdef PARK_STATS_EN
  output logic [NUM_ZONES-1:0]       zone_full,
  output logic [NUM_ZONES*16-1:0]    reject_cnt
`else
  output logic [NUM_ZONES-1:0]       zone_full
`endif
);

  localparam int TW = $clog2(GATE_TIMEOUT + 1);

  gate_state_t          state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ZW-1:0]        zone_q, zone_d;
  logic                 ack_q, ack_d, grant_q, grant_d, err_q;
  logic [CNT_W-1:0]     pub_cap_q;
  logic [CNT_W-1:0]     cnt  [NUM_ZONES];
  logic [CNT_W-1:0]     zcap [NUM_ZONES];
  logic [NUM_ZONES-1:0] inc, rel, ex, unf;
  logic                 entry_ok, exit_ok;
  logic [CNT_W-1:0]     eff_cnt, entry_cap;

  assign entry_ok = int'(entry_zone) < NUM_ZONES;
  assign exit_ok  = int'(exit_zone) < NUM_ZONES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pub_cap_q <= CNT_W'(PUB_BASE_CAP);
    else          pub_cap_q <= CNT_W'(hour_capacity(current_hour, PUB_BASE_CAP));
  end

  // A same-cycle exit on the requested zone frees its slot before the admission check.
  always_comb begin
    eff_cnt   = '0;
    entry_cap = '0;
    if (entry_ok) begin
      eff_cnt   = cnt[entry_zone];
      entry_cap = zcap[entry_zone];
      if (exit_pulse && exit_ok && (exit_zone == entry_zone) && (eff_cnt != '0))
        eff_cnt = eff_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    ex = '0;
    if (exit_pulse && exit_ok) ex[exit_zone] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    zone_d  = zone_q;
    ack_d   = 1'b0;
    grant_d = 1'b0;
    inc     = '0;
    rel     = '0;
    case (state_q)
      IDLE: begin
        if (entry_req && !ack_q) begin
          ack_d = 1'b1;
          if (entry_ok && (eff_cnt < entry_cap)) begin
            grant_d          = 1'b1;
            inc[entry_zone]  = 1'b1;
            zone_d           = entry_zone;
            timer_d          = '0;
            state_d          = OPEN;
          end
        end
      end
      OPEN: begin
        if (car_passed)                             state_d = IDLE;
        else if (timer_q == TW'(GATE_TIMEOUT - 1))  state_d = RELEASE;
        else                                        timer_d = timer_q + TW'(1);
      end
      RELEASE: begin
        rel[zone_q] = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      zone_q  <= '0;
      ack_q   <= 1'b0;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      zone_q  <= zone_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      err_q   <= exit_pulse && exit_ok && unf[exit_zone];
    end
  end

  assign entry_ack   = ack_q;
  assign entry_grant = grant_q;
  assign gate_open   = (state_q == OPEN);
  assign exit_err    = err_q;

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    assign zcap[z] = (z == 0) ? CNT_W'(RSV_CAP) : pub_cap_q;
    parking_zone_counter #(
      .CNT_W   (CNT_W),
      .RST_CAP ((z == 0) ? RSV_CAP : PUB_BASE_CAP)
    ) u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (inc[z]),
      .dec       (rel[z] ^ ex[z]),
      .dec2      (rel[z] & ex[z]),
      .cap       (zcap[z]),
      .count     (cnt[z]),
      .vacancy   (vacancy[z*CNT_W +: CNT_W]),
      .full      (zone_full[z]),
      .underflow (unf[z])
    );
    assign occupancy[z*CNT_W +: CNT_W] = cnt[z];
  end

`ifdef PARK_STATS_EN
  logic [NUM_ZONES-1:0] rej_evt;
  logic [15:0]          rej_q [NUM_ZONES];

  always_comb begin
    rej_evt = rel;
    if (ack_d && !grant_d && entry_ok) rej_evt[entry_zone] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int z = 0; z < NUM_ZONES; z++) rej_q[z] <= '0;
    end else begin
      for (int z = 0; z < NUM_ZONES; z++)
        if (rej_evt[z] && (rej_q[z] != 16'hFFFF)) rej_q[z] <= rej_q[z] + 16'd1;
    end
  end

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_stat
    assign reject_cnt[z*16 +: 16] = rej_q[z];
  end
`endif

endmodule

// File: tb/tb_parking_zone_controller.sv
// Directed scenarios plus a randomized phase, every cycle compared against a zone-level reference model.
module tb_parking_zone_controller;

  localparam int NZ = 2;
  localparam int CW = 10;
  localparam int RSV = 500;
  localparam int BASE = 200;
  localparam int GT = 16;
  localparam int P_IDLE = 0, P_OPEN = 1, P_REL = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [4:0]      current_hour = 5'd8;
  logic            entry_req = 1'b0;
  logic [0:0]      entry_zone = '0;
  logic            entry_ack, entry_grant, gate_open;
  logic            car_passed = 1'b0;
  logic            exit_pulse = 1'b0;
  logic [0:0]      exit_zone = '0;
  logic            exit_err;
  logic [NZ*CW-1:0] occupancy, vacancy;
  logic [NZ-1:0]   zone_full;
`ifdef PARK_STATS_EN
  logic [NZ*16-1:0] reject_cnt;
`endif

  parking_zone_controller #(
    .NUM_ZONES(NZ), .CNT_W(CW), .RSV_CAP(RSV), .PUB_BASE_CAP(BASE), .GATE_TIMEOUT(GT)
  ) dut (
`ifdef PARK_STATS_EN
    .reject_cnt   (reject_cnt),
`endif
    .clk          (clk),
    .reset_n      (reset_n),
    .current_hour (current_hour),
    .entry_req    (entry_req),
    .entry_zone   (entry_zone),
    .entry_ack    (entry_ack),
    .entry_grant  (entry_grant),
    .gate_open    (gate_open),
    .car_passed   (car_passed),
    .exit_pulse   (exit_pulse),
    .exit_zone    (exit_zone),
    .exit_err     (exit_err),
    .occupancy    (occupancy),
    .vacancy      (vacancy),
    .zone_full    (zone_full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_occ [NZ];
  int m_vac [NZ];
  int m_rej [NZ];
  int m_cap, m_phase, m_left, m_zone;
  bit m_ack, m_grant, m_err;

  function automatic int sched_cap(input int hour);
    if (hour >= 13 && hour <= 15) return BASE + 50 * (hour - 12);
    if (hour == 16) return BASE + 300;
    return BASE;
  endfunction

  function automatic int zone_cap(input int z);
    return (z == 0) ? RSV : m_cap;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < NZ; z++) begin
      m_occ[z] = 0;
      m_rej[z] = 0;
      m_vac[z] = (z == 0) ? RSV : BASE;
    end
    m_cap = BASE; m_phase = P_IDLE; m_left = 0; m_zone = 0;
    m_ack = 0; m_grant = 0; m_err = 0;
  endtask

  // Applies the pending inputs to the model as one clock edge would.
  task automatic model_edge();
    int occ_n [NZ];
    int ph, ez, nz;
    occ_n = m_occ;
    ph = m_phase;
    ez = int'(exit_zone);
    nz = int'(entry_zone);
    m_ack = 0; m_grant = 0; m_err = 0;
    if (ph == P_REL) begin
      if (occ_n[m_zone] > 0) occ_n[m_zone]--;
      m_rej[m_zone]++;
      m_phase = P_IDLE;
    end
    if (exit_pulse) begin
      if (occ_n[ez] > 0) occ_n[ez]--;
      else m_err = 1;
    end
    if (ph == P_IDLE && entry_req) begin
      m_ack = 1;
      if (occ_n[nz] < zone_cap(nz)) begin
        m_grant = 1;
        occ_n[nz]++;
        m_phase = P_OPEN;
        m_left = GT;
        m_zone = nz;
      end else m_rej[nz]++;
    end
    if (ph == P_OPEN) begin
      if (car_passed) m_phase = P_IDLE;
      else begin
        m_left--;
        if (m_left == 0) m_phase = P_REL;
      end
    end
    for (int z = 0; z < NZ; z++) begin
      m_vac[z] = (zone_cap(z) > occ_n[z]) ? zone_cap(z) - occ_n[z] : 0;
      m_occ[z] = occ_n[z];
    end
    m_cap = sched_cap(int'(current_hour));
  endtask

  task automatic compare_all();
    check("entry_ack", 32'(entry_ack), 32'(m_ack));
    check("entry_grant", 32'(entry_grant), 32'(m_grant));
    check("gate_open", 32'(gate_open), 32'(m_phase == P_OPEN));
    check("exit_err", 32'(exit_err), 32'(m_err));
    for (int z = 0; z < NZ; z++) begin
      check($sformatf("occ%0d", z), 32'(occupancy[z*CW +: CW]), 32'(m_occ[z]));
      check($sformatf("vac%0d", z), 32'(vacancy[z*CW +: CW]), 32'(m_vac[z]));
      check($sformatf("full%0d", z), 32'(zone_full[z]), 32'(m_vac[z] == 0));
`ifdef PARK_STATS_EN
      check($sformatf("rej%0d", z), 32'(reject_cnt[z*16 +: 16]), 32'(m_rej[z]));
`endif
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    exit_pulse = 1'b0;
    car_passed = 1'b0;
    compare_all();
  endtask

  // Raise a request and hold it until the model expects the ack (bounded).
  task automatic do_req(input int z);
    bit got;
    got = 0;
    entry_req = 1'b1;
    entry_zone = 1'(z);
    for (int k = 0; k < 4 * GT && !got; k++) begin
      tick();
      got = m_ack;
    end
    if (!got) check("ack_timeout", 32'(entry_ack), 32'd1);
    entry_req = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_vac0", 32'(vacancy[0 +: CW]), 32'd500);
    check("rst_vac1", 32'(vacancy[CW +: CW]), 32'd200);
    reset_n = 1'b1;
    tick();

    // 1: single entry into zone 0
    do_req(0);
    check("t1_grant", 32'(entry_grant), 32'd1);
    check("t1_occ0", 32'(occupancy[0 +: CW]), 32'd1);
    check("t1_vac0", 32'(vacancy[0 +: CW]), 32'd499);
    check("t1_gate", 32'(gate_open), 32'd1);
    car_passed = 1'b1;
    tick();
    check("t1_gate_closed", 32'(gate_open), 32'd0);

    // 2: fill zone 1, three rejects, then the 16:00 bonus opens room
    for (int i = 0; i < 200; i++) begin
      do_req(1);
      car_passed = 1'b1;
      tick();
    end
    check("t2_occ1", 32'(occupancy[CW +: CW]), 32'd200);
    for (int i = 0; i < 3; i++) begin
      do_req(1);
      check("t2_reject", 32'(entry_grant), 32'd0);
      check("t2_full1", 32'(zone_full[1]), 32'd1);
      tick();
    end
`ifdef PARK_STATS_EN
    check("t2_rejcnt1", 32'(reject_cnt[16 +: 16]), 32'd3);
`endif
    current_hour = 5'd16;
    tick();
    check("t2_vac1_lag", 32'(vacancy[CW +: CW]), 32'd0);
    tick();
    check("t2_vac1_300", 32'(vacancy[CW +: CW]), 32'd300);
    do_req(1);
    check("t2_grant_after_bonus", 32'(entry_grant), 32'd1);
    car_passed = 1'b1;
    tick();

    // 3: gate timeout releases the reservation
    do_req(1);
    check("t3_occ1_reserved", 32'(occupancy[CW +: CW]), 32'd202);
    repeat (GT - 1) tick();
    check("t3_gate_still_open", 32'(gate_open), 32'd1);
    tick();
    check("t3_gate_closed", 32'(gate_open), 32'd0);
    tick();
    check("t3_occ1_released", 32'(occupancy[CW +: CW]), 32'd201);

    // 5b: capacity drop below occupancy
    for (int i = 0; i < 49; i++) begin
      do_req(1);
      car_passed = 1'b1;
      tick();
    end
    current_hour = 5'd8;
    tick();
    tick();
    check("t5_vac1_zero", 32'(vacancy[CW +: CW]), 32'd0);
    check("t5_occ1_kept", 32'(occupancy[CW +: CW]), 32'd250);
    check("t5_full1", 32'(zone_full[1]), 32'd1);

    // 4: full zone admits when an exit lands on the same cycle
    for (int i = 0; i < 50; i++) begin
      exit_pulse = 1'b1;
      exit_zone = 1'b1;
      tick();
    end
    check("t4_occ1_at_cap", 32'(occupancy[CW +: CW]), 32'd200);
    exit_pulse = 1'b1;
    exit_zone = 1'b1;
    do_req(1);
    check("t4_grant", 32'(entry_grant), 32'd1);
    check("t4_occ1_same", 32'(occupancy[CW +: CW]), 32'd200);
    car_passed = 1'b1;
    tick();

    // 5a: exit from an empty zone
    exit_pulse = 1'b1;
    exit_zone = 1'b0;
    tick();
    check("t5_occ0_zero", 32'(occupancy[0 +: CW]), 32'd0);
    exit_pulse = 1'b1;
    exit_zone = 1'b0;
    tick();
    check("t5_exit_err", 32'(exit_err), 32'd1);
    check("t5_occ0_floor", 32'(occupancy[0 +: CW]), 32'd0);
    tick();
    check("t5_exit_err_pulse", 32'(exit_err), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) current_hour = 5'($urandom_range(0, 31));
      if (!entry_req && !m_ack && $urandom_range(0, 3) == 0) begin
        entry_req = 1'b1;
        entry_zone = 1'($urandom_range(0, NZ - 1));
      end
      if (m_phase == P_OPEN && $urandom_range(0, 5) == 0) car_passed = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        exit_pulse = 1'b1;
        exit_zone = 1'($urandom_range(0, NZ - 1));
      end
      tick();
      if (m_ack) entry_req = 1'b0;
    end
    entry_req = 1'b0;
    while (m_phase != P_IDLE) tick();
    tick();

    // 6: asynchronous reset while the gate is open
    do_req(0);
    tick();
    check("t6_gate_open", 32'(gate_open), 32'd1);
    reset_n = 1'b0;
    #2;
    check("t6_gate_closed_async", 32'(gate_open), 32'd0);
    check("t6_occ_cleared", 32'(occupancy), 32'd0);
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
